// File: rtl/capture_ctrl.sv
// capture_ctrl: arm/pre-trigger/post-trigger sequencer owning the sample memory port, with readout pointer in DONE
module capture_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic [AW-1:0] pretrig,
  input  logic          trig,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic          rd_next,
  input  logic          rd_rewind,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr
);
  typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr, pre_cnt, pretrig_q, start_nx;
  logic [AW:0] post_cnt, post_ld;
  logic go, hit;
  assign go = arm & ~abort;
  assign hit = state == WAIT_TRIG && trig && !abort && !arm;
  assign start_nx = wr_ptr - pretrig_q;
  // a trigger with a coincident sample has already consumed one record slot
  assign post_ld = {1'b1, {AW{1'b0}}} - {1'b0, pretrig_q} - {{AW{1'b0}}, sample_valid};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (arm) state_nx = pretrig == '0 ? WAIT_TRIG : FILL;
    else
      case (state)
        FILL:      if (sample_valid && pre_cnt + AW'(1) == pretrig_q) state_nx = WAIT_TRIG;
        WAIT_TRIG: if (trig) state_nx = post_ld == '0 ? DONE : POST;
        POST:      if (sample_valid && post_cnt == (AW+1)'(1)) state_nx = DONE;
        default:   state_nx = state;
      endcase
  end
  always_comb begin
    busy = state == FILL || state == WAIT_TRIG || state == POST;
    done = state == DONE;
    mem_we = sample_valid & busy;
    mem_wdata = sample;
    mem_addr = busy ? wr_ptr : rd_ptr;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      pretrig_q <= '0;
      trig_addr <= '0;
      start_addr <= '0;
    end else begin
      if (go) begin
        wr_ptr <= '0;
        pre_cnt <= '0;
        pretrig_q <= pretrig;
      end else if (!abort && mem_we) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (state == FILL) pre_cnt <= pre_cnt + AW'(1);
        if (state == POST) post_cnt <= post_cnt - (AW+1)'(1);
      end
      if (hit) begin
        trig_addr <= wr_ptr;
        start_addr <= start_nx;
        post_cnt <= post_ld;
      end
      // start_addr may be written on the same edge that enters DONE
      if (state_nx == DONE && state != DONE) rd_ptr <= hit ? start_nx : start_addr;
      else if (state == IDLE || state == DONE) rd_ptr <= rd_rewind ? start_addr : rd_ptr + AW'(rd_next);
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed and randomized capture records checked against a record-window model
module tb_capture_ctrl;
  localparam int AW = 4, DW = 8, N = 16;
  logic clk = 0, rst = 1, arm = 0, abort = 0, trig = 0, sample_valid = 0, rd_next = 0, rd_rewind = 0;
  logic [AW-1:0] pretrig = '0;
  logic [DW-1:0] sample = '0;
  logic mem_we, busy, done;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_addr, trig_addr, start_addr;
  logic [DW-1:0] mem [N];
  int checks = 0, errors = 0;

  capture_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pretrig(pretrig), .trig(trig),
    .sample_valid(sample_valid), .sample(sample), .rd_next(rd_next), .rd_rewind(rd_rewind),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_addr(mem_addr), .busy(busy), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_we", {31'd0, mem_we}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_trig_addr", {28'd0, trig_addr}, 0);
    check("rst_start_addr", {28'd0, start_addr}, 0);
    check("rst_mem_addr", {28'd0, mem_addr}, 0);
  endtask

  // Record = the N consecutive samples starting pretrig samples before the trigger sample t.
  task automatic run_capture(input int p, input int t, input bit gap, input int spur);
    int last = t - p + N - 1;
    int st = (t - p) % N;
    tick();
    arm = 1; pretrig = AW'(p); sample_valid = 0; trig = 0;
    tick();
    arm = 0;
    for (int i = 0; i <= last; i++) begin
      if (gap && i == t) begin
        sample_valid = 0; trig = 1;
        #1 check("gap_we", {31'd0, mem_we}, 0);
        tick();
      end
      sample_valid = 1; sample = i[7:0];
      trig = (!gap && i == t) || i == spur;
      #1;
      check("wr_we", {31'd0, mem_we}, 1);
      check("wr_addr", {28'd0, mem_addr}, i % N);
      check("wr_busy", {31'd0, busy}, 1);
      check("wr_done", {31'd0, done}, 0);
      tick();
    end
    sample_valid = 0; trig = 0;
    #1;
    check("done_rise", {31'd0, done}, 1);
    check("done_busy", {31'd0, busy}, 0);
    check("trig_addr", {28'd0, trig_addr}, t % N);
    check("start_addr", {28'd0, start_addr}, st);
    check("rd_first_addr", {28'd0, mem_addr}, st);
    for (int i = 0; i < N; i++) begin
      check("rd_addr", {28'd0, mem_addr}, (st + i) % N);
      check("rd_data", {24'd0, mem[mem_addr]}, (t - p + i) & 8'hFF);
      rd_next = 1;
      tick();
      rd_next = 0;
    end
    rd_next = 1;
    tick();
    rd_next = 0;
    #1 check("rd_step", {28'd0, mem_addr}, (st + 1) % N);
    rd_rewind = 1; rd_next = 1;
    tick();
    rd_rewind = 0; rd_next = 0;
    #1 check("rd_rewind", {28'd0, mem_addr}, st);
    check("done_hold", {31'd0, done}, 1);
  endtask

  initial begin
    sample = 8'h5A;
    tick();
    tick();
    rst = 0;
    #1 check_reset_outputs();
    check("wdata_pass", {24'd0, mem_wdata}, 32'h5A);
    run_capture(4, 9, 0, -1);
    run_capture(8, 10, 0, 3);
    run_capture(0, 0, 0, -1);
    run_capture(4, 40, 0, -1);
    run_capture(2, 6, 1, -1);
    run_capture(15, 20, 0, -1);
    run_capture(15, 15, 1, -1);
    for (int r = 0; r < 8; r++) begin
      int p = $urandom_range(0, 15);
      int t = p + $urandom_range(0, 40);
      bit g = 1'($urandom_range(0, 1));
      int s = p > 0 ? $urandom_range(0, p - 1) : -1;
      run_capture(p, t, g, s);
    end
    // abort during POST
    tick();
    arm = 1; pretrig = 4;
    tick();
    arm = 0;
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1; sample = i[7:0]; trig = i == 9;
      tick();
    end
    trig = 0; abort = 1;
    tick();
    abort = 0;
    #1;
    check("abort_we", {31'd0, mem_we}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_trig_addr", {28'd0, trig_addr}, 9);
    arm = 1; abort = 1;
    tick();
    arm = 0; abort = 0;
    #1;
    check("collide_we", {31'd0, mem_we}, 0);
    check("collide_busy", {31'd0, busy}, 0);
    // reset in mid-FILL
    arm = 1; pretrig = 8; sample_valid = 0;
    tick();
    arm = 0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1; sample = i[7:0];
      tick();
    end
    #1 check("fill_busy", {31'd0, busy}, 1);
    rst = 1;
    tick();
    rst = 0;
    #1 check_reset_outputs();
    sample_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
